tlc_gs_frame_loader: RTL and testbench
======================================

// Module: tlc_gs_frame_loader
// PURPOSE
//  Double-buffered grayscale frame store feeding the TLC5955 serial driver.
//  Host writes per-channel 16-bit R/G/B values into a shadow bank, then requests a commit.
//  Banks swap only at a frame boundary signalled by the driver, so a frame is never torn.
//  The active bank is streamed to the driver as 48-bit {B,G,R} channel words over valid/ready, channel NUM_CH-1 first.
// PARAMETERS
//  NUM_CH  16  LED channels per driver; words per frame
//  GS_W    16  grayscale bits per colour
//  ADDR_W  6   host address width; must satisfy 2**ADDR_W >= 3*NUM_CH
// PORTS
//  clk          in   1       single clock; all logic on posedge
//  rst          in   1       asynchronous, active-high reset
//  wr_en        in   1       host write strobe, one write per cycle
//  wr_addr      in   ADDR_W  ch*3 + colour (0=R, 1=G, 2=B)
//  wr_data      in   GS_W    grayscale value
//  commit       in   1       pulse: request bank swap at next frame_start
//  commit_pend  out  1       swap requested, not yet taken
//  frame_start  in   1       pulse from driver: ready to shift a new GS frame
//  word_valid   out  1       word_data/word_last valid
//  word_ready   in   1       driver accepts word
//  word_data    out  3*GS_W  {B,G,R} of current channel
//  word_last    out  1       current word is channel 0
//  overrun      out  1       1-cycle pulse: frame_start arrived while STREAM
// BEHAVIOUR
//  - Reset: both banks zero, active bank = 0, commit_pend = 0, state IDLE, idx = NUM_CH-1.
//    word_valid, word_data, word_last and overrun are all 0.
//  - Writes always target the bank that is shadow in that cycle. wr_addr >= 3*NUM_CH is ignored.
//  - commit sets commit_pend. A repeated commit while pending is idempotent.
//  - FSM IDLE: on frame_start:
//      - if commit_pend, toggle active and clear commit_pend;
//      - load idx = NUM_CH-1;
//      - next cycle enter STREAM with word_valid = 1.
//  - FSM STREAM: word_data/word_last are registered from the active bank at idx and held stable while valid && !ready.
//      - On valid && ready with idx > 0: idx--, next word presented the following cycle.
//      - Throughput is 1 word/cycle when ready is held high.
//      - On valid && ready with word_last: word_valid -> 0, return to IDLE.
//  - Latency: frame_start -> first word_valid = 1 cycle.
//  - frame_start in STREAM: ignored, no swap, overrun pulses 1 cycle.
//  - Simultaneous commit and swapping frame_start: the swap consumes the old request and commit_pend stays 1 (new request).
//  - Simultaneous write and swap: the write lands in the pre-swap shadow, i.e. the newly active bank.
//    The driver sees it only if its channel has not yet been read.
//  - No copy on swap: the new shadow holds the frame from two commits ago; the host rewrites the full frame.
//  - Async rst mid-STREAM: word_valid drops immediately and the frame is abandoned.
// STRUCTURE
//  - Package tlc_pkg holds:
//      - NUM_CH and GS_W defaults;
//      - colour index constants COL_R=0, COL_G=1, COL_B=2;
//      - state enum {S_IDLE, S_STREAM}.
//  - Sub-module tlc_gs_bank: NUM_CH x 3 x GS_W register file.
//      - One write port; one combinational read port by channel returning {B,G,R}.
//      - Instantiated twice, selected by active/~active.
//  - Top holds the FSM, idx counter, commit_pend and output registers.
// TESTING
//  1. rst, then frame_start with ready=1 -> 16 words of 48'h0; last only on the 16th; valid 16 cycles.
//  2. Write ch15 R=16'h1234, G=16'h5678, B=16'h9ABC, then frame_start without commit -> ch15 word still 0.
//     Then commit + frame_start -> first word 48'h9ABC_5678_1234, commit_pend falls.
//  3. ready toggled 1,0,0,1 during STREAM -> word_data stable while stalled; no word skipped or repeated.
//  4. frame_start at word 5 of STREAM -> overrun 1 cycle; the stream continues to word_last unchanged.
//  5. commit in the same cycle as a swapping frame_start -> bank toggles once, commit_pend = 1 afterwards.
//  6. wr_addr = 48..63 written with FFFF -> no bank content changes; async rst mid-STREAM -> outputs 0 same cycle.

Source files
------------

// File: rtl/tlc_pkg.sv
// tlc_pkg: shared sizes, colour indices and FSM state for the TLC5955 frame loader
package tlc_pkg;
    localparam int NUM_CH = 16;
    localparam int GS_W   = 16;
    localparam int COL_R  = 0;
    localparam int COL_G  = 1;
    localparam int COL_B  = 2;
    typedef enum logic {S_IDLE, S_STREAM} state_t;
endpackage

// File: rtl/tlc_gs_bank.sv
// tlc_gs_bank: NUM_CH x 3 x GS_W grayscale register file, one write port, one {B,G,R} read port
module tlc_gs_bank
    import tlc_pkg::*;
#(
    parameter int NUM_CH = tlc_pkg::NUM_CH,
    parameter int GS_W   = tlc_pkg::GS_W,
    parameter int ADDR_W = 6,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [GS_W-1:0]     wr_data,
    input  logic [CH_W-1:0]     rd_ch,
    output logic [3*GS_W-1:0]   rd_data
);
    logic [GS_W-1:0] mem_q [NUM_CH][3];

    // Full-address match per entry, so addresses past the last channel hit nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < 3; k++)
                    mem_q[c][k] <= '0;
        end else if (we) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < 3; k++)
                    if (wr_addr == ADDR_W'(3 * c + k)) mem_q[c][k] <= wr_data;
        end
    end

    assign rd_data = {mem_q[rd_ch][COL_B], mem_q[rd_ch][COL_G], mem_q[rd_ch][COL_R]};
endmodule

// File: rtl/tlc_gs_frame_loader.sv
// tlc_gs_frame_loader: double-buffered GS frame store streaming {B,G,R} words to the TLC5955 driver
module tlc_gs_frame_loader
    import tlc_pkg::*;
#(
    parameter int NUM_CH = tlc_pkg::NUM_CH,
    parameter int GS_W   = tlc_pkg::GS_W,
    parameter int ADDR_W = 6,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [GS_W-1:0]     wr_data,
    input  logic                commit,
    output logic                commit_pend,
    input  logic                frame_start,
    output logic                word_valid,
    input  logic                word_ready,
    output logic [3*GS_W-1:0]   word_data,
    output logic                word_last,
    output logic                overrun
);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     idx_q, idx_d, rd_ch;
    logic                active_q, active_d, commit_pend_q, commit_pend_d;
    logic                last_q, last_d, overrun_q, overrun_d;
    logic [3*GS_W-1:0]   data_q, data_d, rd0, rd1, rd_data;
    logic                swap, fire;

    tlc_gs_bank #(.NUM_CH(NUM_CH), .GS_W(GS_W), .ADDR_W(ADDR_W)) u_bank0 (
        .clk(clk), .rst(rst), .we(wr_en && active_q), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_ch(rd_ch), .rd_data(rd0)
    );
    tlc_gs_bank #(.NUM_CH(NUM_CH), .GS_W(GS_W), .ADDR_W(ADDR_W)) u_bank1 (
        .clk(clk), .rst(rst), .we(wr_en && !active_q), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_ch(rd_ch), .rd_data(rd1)
    );

    // Reads follow the next-cycle active bank so the first word after a swap is already from the new frame
    assign rd_data = active_d ? rd1 : rd0;

    always_comb begin
        swap          = state_q == S_IDLE && frame_start && commit_pend_q;
        fire          = word_valid && word_ready;
        active_d      = active_q ^ swap;
        commit_pend_d = commit || (commit_pend_q && !swap);
        overrun_d     = state_q == S_STREAM && frame_start;
        rd_ch         = state_q == S_STREAM ? idx_q - CH_W'(1) : LAST_CH;
        state_d       = state_q;
        idx_d         = idx_q;
        data_d        = data_q;
        last_d        = last_q;
        if (state_q == S_IDLE && frame_start) begin
            state_d = S_STREAM;
            idx_d   = LAST_CH;
            data_d  = rd_data;
            last_d  = LAST_CH == '0;
        end else if (fire && last_q) begin
            state_d = S_IDLE;
            last_d  = 1'b0;
        end else if (fire) begin
            idx_d  = rd_ch;
            data_d = rd_data;
            last_d = rd_ch == '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= LAST_CH;
            active_q      <= 1'b0;
            commit_pend_q <= 1'b0;
            data_q        <= '0;
            last_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            commit_pend_q <= commit_pend_d;
            data_q        <= data_d;
            last_q        <= last_d;
            overrun_q     <= overrun_d;
        end
    end

    assign word_valid  = state_q == S_STREAM;
    assign word_data   = data_q;
    assign word_last   = last_q;
    assign overrun     = overrun_q;
    assign commit_pend = commit_pend_q;
endmodule

// File: tb/tb_tlc_gs_frame_loader.sv
// tb_tlc_gs_frame_loader: scoreboard bench for the double-buffered TLC5955 frame loader
module tb_tlc_gs_frame_loader;
    logic        clk = 1'b0;
    logic        rst, wr_en, commit, frame_start, word_ready;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        commit_pend, word_valid, word_last, overrun;
    logic [47:0] word_data;

    int tests = 0;
    int fails = 0;
    logic [15:0] bank_m [2][48];
    int          act_m;
    bit          pend_m;
    logic [47:0] exp_q [$];

    always #5 clk = ~clk;

    tlc_gs_frame_loader dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .commit_pend(commit_pend), .frame_start(frame_start),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .word_last(word_last), .overrun(overrun)
    );

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 48; a++)
                bank_m[b][a] = '0;
        act_m  = 0;
        pend_m = 0;
        exp_q.delete();
    endtask

    task automatic host_write(input logic [5:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < 6'd48) bank_m[1-act_m][a] = d;
    endtask

    task automatic write_random_frame();
        for (int a = 0; a < 48; a++) host_write(6'(a), 16'($urandom));
    endtask

    task automatic do_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        pend_m = 1'b1;
    endtask

    task automatic kick(input bit with_commit);
        frame_start = 1'b1;
        commit      = with_commit;
        if (pend_m) act_m = 1 - act_m;
        pend_m = with_commit;
        for (int ch = 15; ch >= 0; ch--)
            exp_q.push_back({bank_m[act_m][ch*3+2], bank_m[act_m][ch*3+1], bank_m[act_m][ch*3]});
        @(negedge clk);
        frame_start = 1'b0;
        commit      = 1'b0;
    endtask

    // Scoreboard consumer: mode 0 ready high, mode 1 ready 1,0,0,1 repeating, mode 2 frame_start at word 5
    task automatic drain(input int mode, input int exp_cyc);
        int          cyc = 0;
        bit          done = 0, stalled = 0, rdy;
        logic [3:0]  pat = 4'b1001;
        logic [47:0] held = '0, exp;
        while (!done && cyc < 100) begin
            if (mode == 2) begin
                tests++;
                if (overrun !== (cyc == 6)) begin
                    fails++;
                    $display("FAIL overrun_pulse cyc=%0d got=%b want=%b", cyc, overrun, cyc == 6);
                end
            end
            frame_start = mode == 2 && cyc == 5;
            tests++;
            if (word_valid !== 1'b1) begin
                fails++;
                $display("FAIL valid_held cyc=%0d got=%b want=1", cyc, word_valid);
                done = 1;
            end else begin
                if (stalled) begin
                    tests++;
                    if (word_data !== held) begin
                        fails++;
                        $display("FAIL stall_stable cyc=%0d got=%h want=%h", cyc, word_data, held);
                    end
                end
                rdy = mode == 1 ? pat[cyc % 4] : 1'b1;
                word_ready = rdy;
                if (rdy) begin
                    exp = exp_q.size() > 0 ? exp_q.pop_front() : 48'hx;
                    tests++;
                    if (word_data !== exp) begin
                        fails++;
                        $display("FAIL word_data cyc=%0d got=%h want=%h", cyc, word_data, exp);
                    end
                    tests++;
                    if (word_last !== (exp_q.size() == 0)) begin
                        fails++;
                        $display("FAIL word_last cyc=%0d got=%b want=%b", cyc, word_last, exp_q.size() == 0);
                    end
                    if (exp_q.size() == 0) done = 1;
                end
                stalled = !rdy;
                held    = word_data;
                cyc++;
                @(negedge clk);
            end
        end
        word_ready  = 1'b0;
        frame_start = 1'b0;
        tests++;
        if (cyc !== exp_cyc) begin
            fails++;
            $display("FAIL frame_cycles got=%0d want=%0d", cyc, exp_cyc);
        end
        tests++;
        if (word_valid !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL end_of_frame valid=%b overrun=%b want 0 0", word_valid, overrun);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL words_left got=%0d want=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({word_valid, word_last, overrun, commit_pend} !== 4'b0 || word_data !== 48'h0) begin
            fails++;
            $display("FAIL reset_outputs v=%b l=%b o=%b p=%b d=%h want all 0",
                     word_valid, word_last, overrun, commit_pend, word_data);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_zero_frame();
        kick(1'b0);
        drain(0, 16);
    endtask

    task automatic test_commit_swap();
        host_write(6'd45, 16'h1234);
        host_write(6'd46, 16'h5678);
        host_write(6'd47, 16'h9ABC);
        kick(1'b0);
        tests++;
        if (word_data !== 48'h0) begin
            fails++;
            $display("FAIL no_commit_word got=%h want=0", word_data);
        end
        drain(0, 16);
        do_commit();
        tests++;
        if (commit_pend !== 1'b1) begin
            fails++;
            $display("FAIL commit_pend_set got=%b want=1", commit_pend);
        end
        kick(1'b0);
        tests++;
        if (word_data !== 48'h9ABC_5678_1234 || commit_pend !== 1'b0) begin
            fails++;
            $display("FAIL swap_first_word got=%h pend=%b want=9abc56781234 pend=0", word_data, commit_pend);
        end
        drain(0, 16);
    endtask

    task automatic test_backpressure();
        write_random_frame();
        do_commit();
        do_commit();
        kick(1'b0);
        drain(1, 32);
    endtask

    task automatic test_overrun();
        kick(1'b0);
        drain(2, 16);
        tests++;
        if (commit_pend !== 1'b0) begin
            fails++;
            $display("FAIL overrun_no_pend got=%b want=0", commit_pend);
        end
        kick(1'b0);
        drain(0, 16);
    endtask

    task automatic test_commit_during_swap();
        write_random_frame();
        do_commit();
        kick(1'b1);
        tests++;
        if (commit_pend !== 1'b1) begin
            fails++;
            $display("FAIL pend_after_swap_commit got=%b want=1", commit_pend);
        end
        drain(0, 16);
        kick(1'b0);
        tests++;
        if (commit_pend !== 1'b0) begin
            fails++;
            $display("FAIL pend_after_second_swap got=%b want=0", commit_pend);
        end
        drain(0, 16);
    endtask

    task automatic test_bad_addr_and_reset();
        for (int a = 48; a < 64; a++) host_write(6'(a), 16'hFFFF);
        do_commit();
        kick(1'b0);
        drain(0, 16);
        kick(1'b0);
        word_ready = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (word_valid !== 1'b0 || word_data !== 48'h0 || word_last !== 1'b0) begin
            fails++;
            $display("FAIL async_reset v=%b d=%h l=%b want 0", word_valid, word_data, word_last);
        end
        word_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        kick(1'b0);
        drain(0, 16);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; frame_start = 1'b0; word_ready = 1'b0;
        model_reset();
        test_reset();
        test_zero_frame();
        test_commit_swap();
        test_backpressure();
        test_overrun();
        test_commit_during_swap();
        test_bad_addr_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end
endmodule
